// File: rtl/ddc_seg_pkg.sv
// Shared definitions for the DDC segment sequencer: state encoding,
// index width helper and the zero-length segment rule.
package ddc_seg_pkg;

  typedef logic [1:0] seg_state_t;

  localparam seg_state_t ST_IDLE = 2'd0;
  localparam seg_state_t ST_RUN  = 2'd1;
  localparam seg_state_t ST_HOLD = 2'd2;

  function automatic int idx_width(input int num_seg);
    return (num_seg > 1) ? $clog2(num_seg) : 1;
  endfunction

  // A zero segment length would never terminate a segment, so treat it as 1.
  function automatic logic [31:0] eff_seg_len(input logic [31:0] len);
    return (len == 32'd0) ? 32'd1 : len;
  endfunction

endpackage

// File: rtl/segment_seq_gen_pri_edge_det.sv
// pri_edge_det: registers a level input and flags its rising edge
// combinationally in the same cycle the new level is sampled.
module pri_edge_det (
  input  logic clk,
  input  logic rst,
  input  logic sig,
  output logic rise
);

  logic sig_d;

  always_ff @(posedge clk) begin
    if (rst) sig_d <= 1'b0;
    else     sig_d <= sig;
  end

  assign rise = sig & ~sig_d;

endmodule

// File: rtl/segment_seq_gen.sv
// Segment sequencer: splits each PRI into NUM_SEG segments of seg_len clocks.
// Optional status outputs (short_pri, pri_cnt) under SEGMENT_SEQ_STATUS_EN.
//
// state   | meaning
// IDLE    | after reset, waiting for the first PRI rise
// RUN     | frame in progress, counters advancing
// HOLD    | one-shot frame finished, frozen until the next rise
module segment_seq_gen
  import ddc_seg_pkg::*;
#(
  parameter int NUM_SEG   = 4,
  parameter int SEG_LEN_W = 16,
  parameter int PRI_CNT_W = 16,
  localparam int IDX_W    = idx_width(NUM_SEG)
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 pri,
  input  logic [SEG_LEN_W-1:0] seg_len,
  input  logic                 mode_oneshot,
  output logic [IDX_W-1:0]     seg_idx,
  output logic                 seg_valid,
  output logic                 seg_start,
  output logic                 frame_start
`ifdef SEGMENT_SEQ_STATUS_EN
  ,
  output logic                 short_pri,
  output logic [PRI_CNT_W-1:0] pri_cnt
`endif
);

  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_SEG - 1);

  if (NUM_SEG < 2 || PRI_CNT_W < 1 || SEG_LEN_W < 1 || SEG_LEN_W > 32) begin : g_param_check
    $error("segment_seq_gen: unsupported parameter set");
  end

  seg_state_t           state;
  logic                 rise;
  logic [SEG_LEN_W-1:0] len_q;
  logic [SEG_LEN_W-1:0] sub_cnt;
  logic                 oneshot_q;

  pri_edge_det u_pri_edge (
    .clk  (clk),
    .rst  (rst),
    .sig  (pri),
    .rise (rise)
  );

  // A rise takes priority over every boundary so a restart always lands on idx 0.
  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= ST_IDLE;
      len_q       <= SEG_LEN_W'(1);
      oneshot_q   <= 1'b0;
      sub_cnt     <= '0;
      seg_idx     <= '0;
      seg_valid   <= 1'b0;
      seg_start   <= 1'b0;
      frame_start <= 1'b0;
    end else begin
      seg_start   <= 1'b0;
      frame_start <= 1'b0;
      if (rise) begin
        len_q       <= SEG_LEN_W'(eff_seg_len(32'(seg_len)));
        oneshot_q   <= mode_oneshot;
        sub_cnt     <= '0;
        seg_idx     <= '0;
        seg_valid   <= 1'b1;
        seg_start   <= 1'b1;
        frame_start <= 1'b1;
        state       <= ST_RUN;
      end else if (state == ST_RUN) begin
        if (sub_cnt == len_q - SEG_LEN_W'(1)) begin
          sub_cnt <= '0;
          if (seg_idx == LAST_IDX) begin
            if (oneshot_q) begin
              state     <= ST_HOLD;
              seg_valid <= 1'b0;
            end else begin
              seg_idx   <= '0;
              seg_start <= 1'b1;
            end
          end else begin
            seg_idx   <= seg_idx + IDX_W'(1);
            seg_start <= 1'b1;
          end
        end else begin
          sub_cnt <= sub_cnt + SEG_LEN_W'(1);
        end
      end
    end
  end

`ifdef SEGMENT_SEQ_STATUS_EN
  // short_pri flags a one-shot frame cut off by a new PRI; sticky until reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      short_pri <= 1'b0;
      pri_cnt   <= '0;
    end else if (rise) begin
      pri_cnt <= pri_cnt + PRI_CNT_W'(1);
      if (state == ST_RUN && oneshot_q) short_pri <= 1'b1;
    end
  end
`endif

endmodule

// File: tb/tb_segment_seq_gen.sv
// Self-checking bench for segment_seq_gen: a frame-position reference model
// pushes expected outputs per clock, compared after each edge.
module tb_segment_seq_gen;

  localparam int NUM_SEG = 4;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        pri = 1'b0;
  logic [15:0] seg_len = 16'd1;
  logic        mode_oneshot = 1'b0;
  logic [1:0]  seg_idx;
  logic        seg_valid;
  logic        seg_start;
  logic        frame_start;
`ifdef SEGMENT_SEQ_STATUS_EN
  logic        short_pri;
  logic [15:0] pri_cnt;
`endif

  segment_seq_gen #(.NUM_SEG(NUM_SEG), .SEG_LEN_W(16), .PRI_CNT_W(16)) dut (
    .clk          (clk),
    .rst          (rst),
    .pri          (pri),
    .seg_len      (seg_len),
    .mode_oneshot (mode_oneshot),
    .seg_idx      (seg_idx),
    .seg_valid    (seg_valid),
    .seg_start    (seg_start),
    .frame_start  (frame_start)
`ifdef SEGMENT_SEQ_STATUS_EN
    ,
    .short_pri    (short_pri),
    .pri_cnt      (pri_cnt)
`endif
  );

  always #5 clk = ~clk;

  typedef struct {
    int idx;
    bit valid;
    bit start;
    bit frame;
    bit short_f;
    int pcnt;
  } exp_t;

  exp_t exp_q[$];
  int   errs   = 0;
  int   checks = 0;
  int   fcount = 0;

  // reference model: position within the frame since the last restart
  int m_pos = 0, m_len = 1, m_idx_hold = 0, m_pcnt = 0;
  bit m_run = 0, m_one = 0, m_prev = 0, m_short = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] want);
    checks++;
    if (got !== want) begin
      errs++;
      $display("FAIL %s: got %0d expected %0d at %0t", tag, got, want, $time);
    end
  endtask

  task automatic model_tick(output exp_t e);
    bit r;
    r = 1'b0;
    if (rst) begin
      m_run = 0; m_prev = 0; m_short = 0; m_pcnt = 0; m_idx_hold = 0; m_pos = 0;
    end else begin
      r = pri && !m_prev;
      m_prev = pri;
      if (r) begin
        if (m_run && m_one) m_short = 1;
        m_len = (seg_len == 16'd0) ? 1 : int'(seg_len);
        m_one = mode_oneshot;
        m_pos = 0;
        m_run = 1;
        m_pcnt++;
      end else if (m_run) begin
        m_pos++;
        if (m_pos >= NUM_SEG * m_len) begin
          if (m_one) begin
            m_run = 0;
            m_idx_hold = NUM_SEG - 1;
          end else begin
            m_pos = 0;
          end
        end
      end
    end
    e.valid   = m_run;
    e.idx     = m_run ? m_pos / m_len : m_idx_hold;
    e.start   = m_run && (m_pos % m_len == 0);
    e.frame   = m_run && r;
    e.short_f = m_short;
    e.pcnt    = m_pcnt & 32'h0000_ffff;
  endtask

  task automatic step();
    exp_t e;
    model_tick(e);
    exp_q.push_back(e);
    @(posedge clk);
    #1;
    e = exp_q.pop_front();
    chk("seg_idx",     32'(seg_idx),     32'(e.idx));
    chk("seg_valid",   32'(seg_valid),   32'(e.valid));
    chk("seg_start",   32'(seg_start),   32'(e.start));
    chk("frame_start", 32'(frame_start), 32'(e.frame));
`ifdef SEGMENT_SEQ_STATUS_EN
    chk("short_pri",   32'(short_pri),   32'(e.short_f));
    chk("pri_cnt",     32'(pri_cnt),     32'(e.pcnt));
`endif
    if (frame_start) fcount++;
  endtask

  task automatic pulse(input int hold);
    pri = 1'b1;
    repeat (hold) step();
    pri = 1'b0;
  endtask

  initial begin
    // reset, then idle with no PRI
    rst = 1'b1;
    repeat (2) step();
    rst = 1'b0;
    repeat (3) step();

    // legacy divide-by-4: seg_len=1, wrap
    seg_len = 16'd1; mode_oneshot = 1'b0;
    pulse(1);
    repeat (10) step();

    // one-shot, 3 clocks per segment, then frozen
    seg_len = 16'd3; mode_oneshot = 1'b1;
    pulse(1);
    repeat (16) step();

    // pri held high mid-frame gives a single restart
    seg_len = 16'd2; mode_oneshot = 1'b0;
    pulse(1);
    repeat (3) step();
    fcount = 0;
    pulse(5);
    repeat (6) step();
    chk("held_pri_frames", 32'(fcount), 32'd1);

    // restart coinciding with a frame wrap boundary
    pulse(1);
    repeat (7) step();
    pulse(1);
    repeat (4) step();

    // short PRI in one-shot mode, then sticky through later PRIs
    seg_len = 16'd10; mode_oneshot = 1'b1;
    pulse(1);
    repeat (14) step();
    pulse(1);
    repeat (5) step();
    seg_len = 16'd1; mode_oneshot = 1'b0;
    pulse(1);
    repeat (4) step();

    // zero length behaves as 1; mid-frame seg_len change ignored
    seg_len = 16'd0;
    pulse(1);
    repeat (3) step();
    seg_len = 16'd5;
    repeat (6) step();
    pulse(1);
    repeat (12) step();

    // reset mid-segment, frozen until next rise
    seg_len = 16'd4; mode_oneshot = 1'b0;
    pulse(1);
    repeat (2) step();
    rst = 1'b1;
    step();
    rst = 1'b0;
    repeat (5) step();
    pulse(1);
    repeat (6) step();

    // randomized PRI traffic
    for (int i = 0; i < 200; i++) begin
      pri          = ($urandom_range(0, 5) == 0);
      seg_len      = 16'($urandom_range(0, 3));
      mode_oneshot = $urandom_range(0, 1) == 1;
      step();
    end

    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end

endmodule
